// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-requester memory port arbiter with read timeout (option: MEM_ARB_PIXEL_PRIO_EN)
module mem_port_arbiter #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 255,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [3*AW-1:0]     req_addr,
  input  logic [3*DW/8-1:0]   req_we,
  input  logic [3*DW-1:0]     req_wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DW-1:0]       rdata,
  output logic                rd_err,
  output logic                cpu_stall,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [AW-1:0]       mem_addr,
  output logic [DW/8-1:0]     mem_we,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [1:0]      r_last;
  logic [1:0]      r_sel;
  logic [AW-1:0]   r_addr;
  logic [BW-1:0]   r_we;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic [2:0]      r_rvalid;
  logic            r_rd_err;
  logic [7:0]      r_cnt;

  logic            w_win_valid;
  logic [1:0]      w_win_idx;
  logic            w_upd_last;
  logic            w_take;
  logic [2:0]      w_gnt;
  logic            w_rd_done;
  logic            w_timeout;
  logic            w_busy;
  logic [2:0]      w_sel_oh;
  logic            w_is_write;

`ifndef MEM_ARB_PIXEL_PRIO_EN
  logic [1:0]      w_c0;
  logic [1:0]      w_c1;
  logic [1:0]      w_c2;
`endif

  assign w_sel_oh   = 3'b001 << r_sel;
  assign w_is_write = |r_we;

  // Pick the next winner among asserted requests
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = 2'd0;
    w_upd_last  = 1'b0;
`ifdef MEM_ARB_PIXEL_PRIO_EN
    // Pixel feeder preempts; 0 and 1 alternate and pixel wins leave last alone
    if (req[2]) begin
      w_win_valid = 1'b1;
      w_win_idx   = 2'd2;
    end else if (r_last == 2'd0) begin
      if (req[1]) begin
        w_win_valid = 1'b1;
        w_win_idx   = 2'd1;
        w_upd_last  = 1'b1;
      end else if (req[0]) begin
        w_win_valid = 1'b1;
        w_win_idx   = 2'd0;
        w_upd_last  = 1'b1;
      end
    end else begin
      if (req[0]) begin
        w_win_valid = 1'b1;
        w_win_idx   = 2'd0;
        w_upd_last  = 1'b1;
      end else if (req[1]) begin
        w_win_valid = 1'b1;
        w_win_idx   = 2'd1;
        w_upd_last  = 1'b1;
      end
    end
`else
    // Search order last+1, last+2, last+3 (mod 3)
    case (r_last)
      2'd0:    begin w_c0 = 2'd1; w_c1 = 2'd2; w_c2 = 2'd0; end
      2'd1:    begin w_c0 = 2'd2; w_c1 = 2'd0; w_c2 = 2'd1; end
      default: begin w_c0 = 2'd0; w_c1 = 2'd1; w_c2 = 2'd2; end
    endcase
    if (req[w_c0]) begin
      w_win_valid = 1'b1;
      w_win_idx   = w_c0;
    end else if (req[w_c1]) begin
      w_win_valid = 1'b1;
      w_win_idx   = w_c1;
    end else if (req[w_c2]) begin
      w_win_valid = 1'b1;
      w_win_idx   = w_c2;
    end
    w_upd_last = w_win_valid;
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, grant pulse and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_gnt       = 3'b000;
    w_rd_done   = 1'b0;
    w_timeout   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_take      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A write is finished the moment memory accepts it
        w_busy = (r_sel != 2'd2) && !(w_is_write && mem_ready);
        if (mem_ready) begin
          w_gnt       = w_sel_oh;
          w_state_nxt = w_is_write ? S_IDLE : S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        w_busy = (r_sel != 2'd2);
        // A response arriving in the timeout cycle still carries real data
        if (mem_rvalid) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 8'(TIMEOUT)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch the winner's payload, track the timeout and register read results
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last   <= 2'd2;
      r_sel    <= 2'd0;
      r_addr   <= '0;
      r_we     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 3'b000;
      r_rd_err <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      r_rvalid <= 3'b000;
      r_rd_err <= 1'b0;
      if (w_take) begin
        r_sel   <= w_win_idx;
        r_addr  <= req_addr[w_win_idx*AW +: AW];
        r_we    <= req_we[w_win_idx*BW +: BW];
        r_wdata <= req_wdata[w_win_idx*DW +: DW];
        if (w_upd_last) begin
          r_last <= w_win_idx;
        end
      end
      // Held at zero through ISSUE so WAIT_RD always starts from a clean count
      if (r_state == S_WAIT_RD) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end
      if (w_rd_done) begin
        r_rdata  <= mem_rdata;
        r_rvalid <= w_sel_oh;
      end else if (w_timeout) begin
        r_rdata  <= ERR_DATA;
        r_rvalid <= w_sel_oh;
        r_rd_err <= 1'b1;
      end
    end
  end

  assign gnt       = w_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign rd_err    = r_rd_err;
  assign cpu_stall = req[0] | req[1] | w_busy;
  assign mem_valid = (r_state == S_ISSUE);
  assign mem_addr  = r_addr;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0004;
  localparam logic [31:0] A1 = 32'h2000_0008;
  localparam logic [31:0] A2 = 32'h3000_000C;

  logic         clk;
  logic         rst;
  logic [2:0]   req;
  logic [95:0]  req_addr;
  logic [11:0]  req_we;
  logic [95:0]  req_wdata;
  logic [2:0]   gnt;
  logic [2:0]   rvalid;
  logic [31:0]  rdata;
  logic         rd_err;
  logic         cpu_stall;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_addr;
  logic [3:0]   mem_we;
  logic [31:0]  mem_wdata;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  int total;
  int bad;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rd_err     (rd_err),
    .cpu_stall  (cpu_stall),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        rdy;
    logic        mrv;
    logic [31:0] mrd;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic        st;
    logic        mv;
    logic [31:0] ad;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic rdy,
                              input logic mrv, input logic [31:0] mrd, input logic [2:0] g,
                              input logic [2:0] rv, input logic st, input logic mv,
                              input logic [31:0] ad, input logic [31:0] rd);
    vec_t v;
    v.rst = r;  v.req = rq; v.rdy = rdy; v.mrv = mrv; v.mrd = mrd;
    v.gnt = g;  v.rv = rv;  v.st = st;   v.mv = mv;   v.ad = ad; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, let outputs settle mid-cycle
  task automatic cyc(input logic r, input logic [2:0] rq, input logic rdy,
                     input logic mrv, input logic [31:0] mrd);
    @(posedge clk);
    #1;
    rst        = r;
    req        = rq;
    mem_ready  = rdy;
    mem_rvalid = mrv;
    mem_rdata  = mrd;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    req        = 3'b000;
    req_addr   = {A2, A1, A0};
    req_we     = 12'h000;
    req_wdata  = {32'hCCCC_0002, 32'h1234_5678, 32'hAAAA_0000};
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    //             rst req    rdy mrv mrd           gnt     rv     st mv addr rdata
    tbl[0]  = mk(0, 3'b000, 0, 0, 32'h0,        3'b000, 3'b000, 0, 0, 0,  32'h0);
    tbl[1]  = mk(1, 3'b001, 0, 0, 32'h0,        3'b000, 3'b000, 1, 0, 0,  32'h0);
    tbl[2]  = mk(1, 3'b001, 1, 0, 32'h0,        3'b001, 3'b000, 1, 1, A0, 32'h0);
    tbl[3]  = mk(1, 3'b000, 0, 1, 32'hCAFEF00D, 3'b000, 3'b000, 1, 0, 0,  32'h0);
    tbl[4]  = mk(1, 3'b000, 0, 0, 32'h0,        3'b000, 3'b001, 0, 0, 0,  32'hCAFEF00D);
    tbl[5]  = mk(0, 3'b000, 0, 0, 32'h0,        3'b000, 3'b000, 0, 0, 0,  32'hCAFEF00D);
    tbl[6]  = mk(1, 3'b111, 1, 0, 32'h0,        3'b000, 3'b000, 1, 0, 0,  32'h0);
    tbl[7]  = mk(1, 3'b111, 1, 0, 32'h0,        3'b001, 3'b000, 1, 1, A0, 32'h0);
    tbl[8]  = mk(1, 3'b111, 1, 1, 32'hD0,       3'b000, 3'b000, 1, 0, 0,  32'h0);
    tbl[9]  = mk(1, 3'b111, 1, 0, 32'h0,        3'b000, 3'b001, 1, 0, 0,  32'hD0);
    tbl[10] = mk(1, 3'b111, 1, 0, 32'h0,        3'b010, 3'b000, 1, 1, A1, 32'hD0);
    tbl[11] = mk(1, 3'b111, 1, 1, 32'hD1,       3'b000, 3'b000, 1, 0, 0,  32'hD0);
    tbl[12] = mk(1, 3'b111, 1, 0, 32'h0,        3'b000, 3'b010, 1, 0, 0,  32'hD1);
    tbl[13] = mk(1, 3'b111, 1, 0, 32'h0,        3'b100, 3'b000, 1, 1, A2, 32'hD1);
    tbl[14] = mk(1, 3'b111, 1, 1, 32'hD2,       3'b000, 3'b000, 1, 0, 0,  32'hD1);
    tbl[15] = mk(1, 3'b111, 1, 0, 32'h0,        3'b000, 3'b100, 1, 0, 0,  32'hD2);
    tbl[16] = mk(1, 3'b111, 1, 0, 32'h0,        3'b001, 3'b000, 1, 1, A0, 32'hD2);
    tbl[17] = mk(1, 3'b111, 1, 1, 32'hD3,       3'b000, 3'b000, 1, 0, 0,  32'hD2);
    tbl[18] = mk(1, 3'b111, 1, 0, 32'h0,        3'b000, 3'b001, 1, 0, 0,  32'hD3);
    tbl[19] = mk(1, 3'b111, 1, 0, 32'h0,        3'b010, 3'b000, 1, 1, A1, 32'hD3);
    tbl[20] = mk(1, 3'b111, 1, 1, 32'hD4,       3'b000, 3'b000, 1, 0, 0,  32'hD3);
    tbl[21] = mk(1, 3'b111, 1, 0, 32'h0,        3'b000, 3'b010, 1, 0, 0,  32'hD4);
    tbl[22] = mk(1, 3'b111, 1, 0, 32'h0,        3'b100, 3'b000, 1, 1, A2, 32'hD4);
    tbl[23] = mk(1, 3'b000, 1, 1, 32'hD5,       3'b000, 3'b000, 0, 0, 0,  32'hD4);
    tbl[24] = mk(1, 3'b000, 1, 0, 32'h0,        3'b000, 3'b100, 0, 0, 0,  32'hD5);

    cyc(0, 3'b000, 0, 0, 32'h0);
    cyc(0, 3'b000, 0, 0, 32'h0);

    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].mrv, tbl[i].mrd);
      chk($sformatf("v%0d.gnt", i),    {29'd0, gnt},       {29'd0, tbl[i].gnt});
      chk($sformatf("v%0d.rvalid", i), {29'd0, rvalid},    {29'd0, tbl[i].rv});
      chk($sformatf("v%0d.rd_err", i), {31'd0, rd_err},    32'd0);
      chk($sformatf("v%0d.stall", i),  {31'd0, cpu_stall}, {31'd0, tbl[i].st});
      chk($sformatf("v%0d.mvalid", i), {31'd0, mem_valid}, {31'd0, tbl[i].mv});
      chk($sformatf("v%0d.rdata", i),  rdata,              tbl[i].rd);
      if (tbl[i].mv) chk($sformatf("v%0d.addr", i), mem_addr, tbl[i].ad);
    end

    // Write from requester 1 held off by mem_ready for five cycles
    req_we = 12'h030;
    cyc(1, 3'b010, 0, 0, 32'h0);
    chk("wr.idle_mvalid", {31'd0, mem_valid}, 32'd0);
    chk("wr.idle_stall",  {31'd0, cpu_stall}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 3'b010, 0, 0, 32'h0);
      chk($sformatf("wr%0d.mvalid", k), {31'd0, mem_valid}, 32'd1);
      chk($sformatf("wr%0d.gnt", k),    {29'd0, gnt},       32'd0);
      chk($sformatf("wr%0d.addr", k),   mem_addr,           A1);
      chk($sformatf("wr%0d.we", k),     {28'd0, mem_we},    32'h3);
      chk($sformatf("wr%0d.wdata", k),  mem_wdata,          32'h1234_5678);
    end
    cyc(1, 3'b010, 1, 0, 32'h0);
    chk("wr6.mvalid", {31'd0, mem_valid}, 32'd1);
    chk("wr6.gnt",    {29'd0, gnt},       32'b010);
    chk("wr6.we",     {28'd0, mem_we},    32'h3);
    cyc(1, 3'b000, 0, 0, 32'h0);
    chk("wr7.mvalid", {31'd0, mem_valid}, 32'd0);
    chk("wr7.rvalid", {29'd0, rvalid},    32'd0);
    chk("wr7.stall",  {31'd0, cpu_stall}, 32'd0);
    cyc(1, 3'b000, 0, 1, 32'h9999);
    cyc(1, 3'b000, 0, 0, 32'h0);
    chk("wr9.rvalid", {29'd0, rvalid}, 32'd0);
    chk("wr9.rdata",  rdata,           32'hD5);
    req_we = 12'h000;

    // Read that never gets a response: abort after TIMEOUT
    cyc(1, 3'b001, 1, 0, 32'h0);
    cyc(1, 3'b001, 1, 0, 32'h0);
    chk("to.gnt", {29'd0, gnt}, 32'b001);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      cyc(1, 3'b000, 0, 0, 32'h0);
      if (rvalid !== 3'b000) break;
      n++;
    end
    chk("to.wait_cycles", n,                 32'd256);
    chk("to.rvalid",      {29'd0, rvalid},   32'b001);
    chk("to.rd_err",      {31'd0, rd_err},   32'd1);
    chk("to.rdata",       rdata,             32'hDEADBEEF);
    chk("to.stall",       {31'd0, cpu_stall}, 32'd0);
    cyc(1, 3'b000, 0, 1, 32'h1111);
    chk("to.stray_rvalid", {29'd0, rvalid}, 32'd0);
    chk("to.stray_err",    {31'd0, rd_err}, 32'd0);
    cyc(1, 3'b000, 0, 0, 32'h0);
    chk("to.stray_rvalid2", {29'd0, rvalid}, 32'd0);
    chk("to.stray_rdata",   rdata,           32'hDEADBEEF);

    // Response arriving in the very cycle the count hits TIMEOUT wins
    cyc(1, 3'b001, 1, 0, 32'h0);
    cyc(1, 3'b001, 1, 0, 32'h0);
    chk("race.gnt", {29'd0, gnt}, 32'b001);
    for (int k = 0; k < 255; k++) cyc(1, 3'b000, 0, 0, 32'h0);
    cyc(1, 3'b000, 0, 1, 32'h5A5A_5A5A);
    chk("race.pre_rvalid", {29'd0, rvalid}, 32'd0);
    cyc(1, 3'b000, 0, 0, 32'h0);
    chk("race.rvalid", {29'd0, rvalid}, 32'b001);
    chk("race.rd_err", {31'd0, rd_err}, 32'd0);
    chk("race.rdata",  rdata,           32'h5A5A_5A5A);

    // Reset while waiting for read data; the late response is dropped
    cyc(1, 3'b001, 1, 0, 32'h0);
    cyc(1, 3'b001, 1, 0, 32'h0);
    cyc(1, 3'b000, 0, 0, 32'h0);
    cyc(1, 3'b000, 0, 0, 32'h0);
    cyc(0, 3'b000, 0, 0, 32'h0);
    cyc(1, 3'b000, 0, 1, 32'h4444);
    chk("rst.mvalid", {31'd0, mem_valid}, 32'd0);
    chk("rst.gnt",    {29'd0, gnt},       32'd0);
    chk("rst.rvalid", {29'd0, rvalid},    32'd0);
    chk("rst.rdata",  rdata,              32'd0);
    chk("rst.addr",   mem_addr,           32'd0);
    chk("rst.stall",  {31'd0, cpu_stall}, 32'd0);
    cyc(1, 3'b000, 0, 0, 32'h0);
    chk("rst.rvalid2", {29'd0, rvalid}, 32'd0);
    chk("rst.rdata2",  rdata,           32'd0);
    cyc(1, 3'b001, 1, 0, 32'h0);
    chk("post.stall", {31'd0, cpu_stall}, 32'd1);
    cyc(1, 3'b001, 1, 0, 32'h0);
    chk("post.gnt",  {29'd0, gnt}, 32'b001);
    chk("post.addr", mem_addr,     A0);
    cyc(1, 3'b000, 0, 1, 32'h7777);
    cyc(1, 3'b000, 0, 0, 32'h0);
    chk("post.rvalid", {29'd0, rvalid},    32'b001);
    chk("post.rdata",  rdata,              32'h7777);
    chk("post.stall2", {31'd0, cpu_stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared memory request port among three requesters: instruction-cache fill (0), data-cache fill/write (1) and the pixel/frame-buffer feeder (2). It sits between the cache/memory-system logic around the CPU core and the single external memory port. It runs one transaction at a time through a small FSM, with round-robin or pixel-priority arbitration and a read timeout. It also drives the CPU stall for outstanding cache requests.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; byte-enable width is `DW/8`
- `TIMEOUT`, 255, maximum cycles spent in WAIT_RD before the read is aborted (8-bit counter)
- `ERR_DATA`, 32'hDEADBEEF, read data returned when a read is aborted

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `req`  in  3  per-requester request level
- `req_addr`  in  3*AW  flat; requester i at `[i*AW +: AW]`
- `req_we`  in  3*DW/8  per-requester byte write enables; all zero means read
- `req_wdata`  in  3*DW  per-requester write data
- `gnt`  out  3  one-hot pulse: the requester's transaction was accepted by memory
- `rvalid`  out  3  one-hot pulse: read data is valid on `rdata`
- `rdata`  out  DW  read data, shared by all requesters
- `rd_err`  out  1  pulse accompanying an aborted (timed-out) read
- `cpu_stall`  out  1  requester 0 or 1 has an unfinished transaction
- `mem_valid`  out  1  request valid to memory
- `mem_ready`  in  1  memory accepts the request
- `mem_addr`  out  AW  request address
- `mem_we`  out  DW/8  request byte enables
- `mem_wdata`  out  DW  request write data
- `mem_rvalid`  in  1  read response valid
- `mem_rdata`  in  DW  read response data

## Operation
- FSM states:
  - **IDLE**: arbitrate among the asserted `req` bits. On a winner, latch its index `sel`, address, byte enables and write data into registers; go to ISSUE.
  - **ISSUE**: `mem_valid` is 1 and the latched fields drive the `mem_*` outputs. Hold until `mem_ready`. When `mem_valid & mem_ready`: `gnt[sel]` is 1 that cycle (combinational). Go to IDLE if the latched `mem_we` is nonzero, otherwise to WAIT_RD.
  - **WAIT_RD**: on `mem_rvalid`, register `rdata` = `mem_rdata` and pulse `rvalid[sel]` on the next cycle; go to IDLE. If the counter reaches `TIMEOUT` first: `rdata` = `ERR_DATA`, `rvalid[sel]` and `rd_err` pulse together, go to IDLE.
- Round-robin:
  - Pointer `last` holds the most recent winner.
  - Search order is last+1, last+2, last+3, mod 3.
  - `last` updates on the IDLE→ISSUE transition.
- Requester rules:
  - Hold `req` and its payload until `gnt`.
  - Deassert `req` no later than the cycle after `gnt`. Requesters drive `req` from registers.
  - Payload changes after the IDLE→ISSUE transition are ignored.
- `mem_rvalid` in IDLE or ISSUE (a stale or late response) is ignored.
- `cpu_stall` = (`req[0]` | `req[1]`), or (state ≠ IDLE and `sel` ∈ {0,1} and the transaction is unfinished). It is combinational and deasserts in the cycle `rvalid[sel]` or the write `gnt[sel]` is seen.
- Requesters 0 and 1 are expected to issue reads in the sense of cache fills; all three may issue writes.

## Timing
- Reset values: state IDLE, `last`=2 (requester 0 wins the first tie), all of `gnt`/`rvalid`/`rd_err`/`mem_valid`=0, `mem_addr`/`mem_we`/`mem_wdata`/`rdata`=0, timeout counter=0.
- Reset asserted mid-transaction: return to IDLE next edge. The pending read response is dropped with no `rvalid`.
- Minimum write: `req` at T, `mem_valid` at T+1, `gnt` at T+1 if `mem_ready`=1. The next arbitration is at T+2.
- Minimum read: `req` at T, accept at T+1, `mem_rvalid` at T+2, `rvalid` at T+3.
- The timeout counter clears on WAIT_RD entry and increments each WAIT_RD cycle. The abort fires in the cycle after the count equals `TIMEOUT`. `mem_rvalid` in the same cycle as the timeout wins: real data is returned and `rd_err`=0.
- Back-to-back transactions always have at least one IDLE cycle between them.

## Configuration
- `MEM_ARB_PIXEL_PRIO_EN`:
  - Defined: requester 2 wins whenever `req[2]`=1 in IDLE, regardless of `last`. Requesters 0/1 round-robin between themselves, and `last` is not updated on pixel wins.
  - Undefined: pure three-way round-robin as above.

## Test plan
- Single read from req 0, addr 32'h1000_0004, `mem_ready`=1, `mem_rvalid` one cycle after accept with 32'hCAFEF00D → `gnt`=3'b001 at T+1, `rvalid`=3'b001 at T+3 with `rdata`=32'hCAFEF00D; `cpu_stall` high T..T+2, low at T+3.
- All three requesting reads continuously (round-robin build) → grant order 0,1,2,0,1,2.
  - With `MEM_ARB_PIXEL_PRIO_EN`: 2 wins while `req[2]` is held.
- Write from req 1, `mem_we`=4'b0011, `mem_ready` low 5 cycles → `mem_valid` held 6 cycles with stable fields, `gnt[1]` in the 6th, no `rvalid`.
- Read with `mem_rvalid` never asserted, `TIMEOUT`=255 → `rvalid[sel]`+`rd_err` with `rdata`=32'hDEADBEEF; a later stray `mem_rvalid` in IDLE causes no pulse.
- `rst`=0 while in WAIT_RD, then `mem_rvalid` arrives → all outputs 0 and no `rvalid`. The next request from 0 is served normally.
